// File: rtl/stat_disp_pkg.sv
// Shared constants, FSM state type and mode rotation for the stat display sequencer.
// HAT_DISPLAY_EN selects the 4-mode rotation that includes high-activity time.
package stat_disp_pkg;

  localparam logic [1:0] MODE_STEPS  = 2'd0;
  localparam logic [1:0] MODE_DIST   = 2'd1;
  localparam logic [1:0] MODE_OVER32 = 2'd2;
  localparam logic [1:0] MODE_HAT    = 2'd3;

  localparam logic [15:0] SAT_LIMIT = 16'd9999;
  localparam logic [3:0]  DP_DIST   = 4'b0010;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONV
  } state_t;

  function automatic logic [1:0] next_mode(input logic [1:0] m);
`ifdef HAT_DISPLAY_EN
    return m + 2'd1;
`else
    return (m == MODE_OVER32) ? MODE_STEPS : m + 2'd1;
`endif
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to 4 BCD digits.
// Samples on start, shifts 14 times, then raises done for one cycle.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [13:0] i_bin,
  output logic        o_done,
  output logic [15:0] o_bcd
);

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [15:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < 4; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bin  <= '0;
      r_bcd  <= '0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= 4'd14;
        r_bin  <= i_bin;
        r_bcd  <= '0;
      end
    end else if (r_cnt != 4'd0) begin
      r_bcd <= {w_adj[14:0], r_bin[13]};
      r_bin <= {r_bin[12:0], 1'b0};
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == 4'd0);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/stat_display_sequencer.sv
// Rotates tracker statistics onto a shared 4-digit BCD display path.
// Build macro HAT_DISPLAY_EN adds high-activity time as a fourth mode.
module stat_display_sequencer
  import stat_disp_pkg::*;
#(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int DWELL_S     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] step_count,
  input  logic [15:0] distance_x10,
  input  logic [15:0] over32_s,
  input  logic [9:0]  hat,
  input  logic        hold,
  output logic [15:0] bcd,
  output logic [1:0]  mode,
  output logic [3:0]  dp_mask,
  output logic        sat,
  output logic        bcd_valid
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
  localparam int DW = (DWELL_S > 1) ? $clog2(DWELL_S) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DWELL_S - 1);

  logic [TW-1:0] r_tcnt;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_sel;
  logic [1:0]    r_ld_mode;
  logic [3:0]    r_ld_dp;
  logic          r_ld_sat;
  state_t        r_state;
  state_t        w_next;
  logic          w_tick;
  logic          w_start;
  logic          w_done;
  logic          w_sat;
  logic [15:0]   w_src;
  logic [15:0]   w_conv;
  logic [13:0]   w_clamp;

  assign w_tick = (r_tcnt == TMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tcnt <= '0;
    else if (w_tick) r_tcnt <= '0;
    else r_tcnt <= r_tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dwell <= '0;
      r_sel   <= MODE_STEPS;
    end else if (w_tick) begin
      if (r_dwell == DMAX && !hold) begin
        r_sel   <= next_mode(r_sel);
        r_dwell <= '0;
      end else if (r_dwell != DMAX) begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  always_comb begin
    w_src = step_count;
    unique case (r_sel)
      MODE_STEPS:  w_src = step_count;
      MODE_DIST:   w_src = distance_x10;
      MODE_OVER32: w_src = over32_s;
      MODE_HAT:    w_src = {6'd0, hat};
    endcase
  end

  assign w_sat   = (w_src > SAT_LIMIT);
  assign w_clamp = w_sat ? SAT_LIMIT[13:0] : w_src[13:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    unique case (r_state)
      IDLE: if (w_tick) w_next = LOAD;
      LOAD: begin
        w_start = 1'b1;
        w_next  = CONV;
      end
      CONV: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_start),
    .i_bin   (w_clamp),
    .o_done  (w_done),
    .o_bcd   (w_conv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_mode <= MODE_STEPS;
      r_ld_dp   <= '0;
      r_ld_sat  <= 1'b0;
    end else if (r_state == LOAD) begin
      r_ld_mode <= r_sel;
      r_ld_dp   <= (r_sel == MODE_DIST) ? DP_DIST : 4'b0000;
      r_ld_sat  <= w_sat;
    end
  end

  // Display fields change together, only on a completed conversion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd       <= '0;
      mode      <= '0;
      dp_mask   <= '0;
      sat       <= 1'b0;
      bcd_valid <= 1'b0;
    end else if (r_state == CONV && w_done) begin
      bcd       <= w_conv;
      mode      <= r_ld_mode;
      dp_mask   <= r_ld_dp;
      sat       <= r_ld_sat;
      bcd_valid <= 1'b1;
    end else begin
      bcd_valid <= 1'b0;
    end
  end

  a_no_tick_busy: assert property (
    @(posedge clk) disable iff (!reset) w_tick |-> (r_state == IDLE)
  );

endmodule

// File: tb/tb_stat_display_sequencer.sv
// Directed bench for stat_display_sequencer with TICK_CYCLES=32, DWELL_S=2.
// Expected mode sequence follows HAT_DISPLAY_EN as built.
module tb_stat_display_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] step_count;
  logic [15:0] distance_x10;
  logic [15:0] over32_s;
  logic [9:0]  hat;
  logic        hold;
  logic [15:0] bcd;
  logic [1:0]  mode;
  logic [3:0]  dp_mask;
  logic        sat;
  logic        bcd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  stat_display_sequencer #(
    .TICK_CYCLES (32),
    .DWELL_S     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .step_count   (step_count),
    .distance_x10 (distance_x10),
    .over32_s     (over32_s),
    .hat          (hat),
    .hold         (hold),
    .bcd          (bcd),
    .mode         (mode),
    .dp_mask      (dp_mask),
    .sat          (sat),
    .bcd_valid    (bcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge where reset was released (cycle 0)
  task automatic post_reset(input string tag, input logic [15:0] exp_bcd);
    logic early;
    early = 1'b0;
    for (int i = 1; i <= 47; i++) begin
      step_cycle();
      if (bcd_valid || bcd != 0 || mode != 0 || dp_mask != 0 || sat)
        early = 1'b1;
    end
    check({tag, "_quiet"}, {31'd0, early}, 32'd0);
    step_cycle();
    check({tag, "_valid48"}, {31'd0, bcd_valid}, 32'd1);
    check({tag, "_bcd"}, {16'd0, bcd}, {16'd0, exp_bcd});
    check({tag, "_mode"}, {30'd0, mode}, 32'd0);
    check({tag, "_sat"}, {31'd0, sat}, 32'd0);
    step_cycle();
    check({tag, "_pulse1"}, {31'd0, bcd_valid}, 32'd0);
  endtask

  task automatic wait_refresh(input string tag, input logic [15:0] exp_bcd,
                              input logic [1:0] exp_mode,
                              input logic [3:0] exp_dp, input logic exp_sat);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step_cycle();
      if (bcd_valid) seen = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_bcd"}, {16'd0, bcd}, {16'd0, exp_bcd});
    check({tag, "_mode"}, {30'd0, mode}, {30'd0, exp_mode});
    check({tag, "_dp"}, {28'd0, dp_mask}, {28'd0, exp_dp});
    check({tag, "_sat"}, {31'd0, sat}, {31'd0, exp_sat});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    step_count   = 16'd1234;
    distance_x10 = 16'd57;
    over32_s     = 16'd12000;
    hat          = 10'd600;
    hold         = 1'b0;
    #1 reset = 1'b0;
    repeat (3) step_cycle();
    check("rst_outs", {7'd0, bcd, mode, dp_mask, sat, bcd_valid}, 32'd0);

    reset = 1'b1;
    post_reset("first", 16'h1234);

    wait_refresh("r1_dist", 16'h0057, 2'd1, 4'b0010, 1'b0);
    wait_refresh("r2_dist", 16'h0057, 2'd1, 4'b0010, 1'b0);
    wait_refresh("r3_sat", 16'h9999, 2'd2, 4'b0000, 1'b1);
    over32_s = 16'd42;
    wait_refresh("r4_unsat", 16'h0042, 2'd2, 4'b0000, 1'b0);
    step_count = 16'd10;
`ifdef HAT_DISPLAY_EN
    wait_refresh("r5_hat", 16'h0600, 2'd3, 4'b0000, 1'b0);
    wait_refresh("r6_hat", 16'h0600, 2'd3, 4'b0000, 1'b0);
    wait_refresh("r7_wrap", 16'h0010, 2'd0, 4'b0000, 1'b0);
`else
    wait_refresh("r5_wrap", 16'h0010, 2'd0, 4'b0000, 1'b0);
    wait_refresh("r6_steps", 16'h0010, 2'd0, 4'b0000, 1'b0);
`endif

    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) step_count = 16'd11;
      wait_refresh($sformatf("hold%0d", i), (i >= 3) ? 16'h0011 : 16'h0010,
                   2'd0, 4'b0000, 1'b0);
    end
    hold = 1'b0;
    wait_refresh("unhold", 16'h0057, 2'd1, 4'b0010, 1'b0);

    // Next tick is 15 cycles after this refresh; drop reset 8 cycles later
    repeat (23) step_cycle();
    reset = 1'b0;
    #1;
    check("midrst_outs", {7'd0, bcd, mode, dp_mask, sat, bcd_valid}, 32'd0);
    step_count = 16'd4321;
    repeat (3) step_cycle();
    check("midrst_hold", {7'd0, bcd, mode, dp_mask, sat, bcd_valid}, 32'd0);
    reset = 1'b1;
    post_reset("after_rst", 16'h4321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stat_display_sequencer.md
# stat_display_sequencer

Time-multiplexes the tracker's statistics (step count, distance, seconds above 32 steps/s, high-activity time) onto one shared 4-digit BCD display path. The block runs a 1 s tick and rotates the displayed statistic every `DWELL_S` ticks. On every tick it sequences a multi-cycle binary-to-BCD conversion of the selected source and registers the result, with decimal-point and saturation flags, for the seven-segment driver. It sits between the activity datapath counters and the display mux.

## Interface
- `TICK_CYCLES`, 100_000_000: clocks per 1 s tick; must be ≥ 32.
- `DWELL_S`, 2: ticks each statistic stays on display; must be ≥ 1.
- `clk`  in  1  system clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it low clears all state immediately.
- `step_count`  in  16  total steps, binary.
- `distance_x10`  in  16  distance in tenths of a mile, binary.
- `over32_s`  in  16  seconds spent above 32 steps/s, binary.
- `hat`  in  10  high-activity time from the activity tracker, binary, zero-extended.
- `hold`  in  1  while high, freezes rotation; refreshes continue.
- `bcd`  out  16  four BCD digits; [15:12] is the most significant digit.
- `mode`  out  2  statistic currently shown: 0 steps, 1 distance, 2 over32, 3 hat.
- `dp_mask`  out  4  decimal-point enables, one bit per digit.
- `sat`  out  1  the shown value was clamped to 9999.
- `bcd_valid`  out  1  one-cycle pulse when `bcd`/`mode`/`dp_mask`/`sat` update.

## Operation
- **Reset values:** all outputs are 0. The tick counter, dwell counter and FSM are cleared (FSM = IDLE). The converter is idle.
- **Tick generator:** the counter runs 0..`TICK_CYCLES`-1 and wraps. `tick` is high for one cycle when the count equals `TICK_CYCLES`-1.
- **Dwell:** on each `tick`:
  - if the dwell count equals `DWELL_S`-1 and `hold` is 0, the selection advances to the next mode and dwell clears;
  - otherwise dwell increments, saturating at `DWELL_S`-1 while `hold` is 1.
- **Mode order:** 0→1→2→3→0. If the `HAT_DISPLAY_EN` macro is undefined, the order is 0→1→2→0.
- **FSM states:**
  - IDLE: on `tick` → LOAD.
  - LOAD: latch the selected source (using the mode already updated by this tick), clamp it, pulse the converter `start`, → CONV.
  - CONV: wait for converter `done`. On `done`, register `bcd`, `mode`, `dp_mask` and `sat`, pulse `bcd_valid`, → IDLE.
- **Clamp:** a value > 9999 is replaced by 9999 and `sat`=1; otherwise `sat`=0. The clamped value is 14 bits.
- **`dp_mask`:** 4'b0010 in distance mode (shows XXX.X); 4'b0000 in all other modes.
- **Source sampling:** each source is sampled only in LOAD. Input changes during CONV are not displayed until the next tick.
- **Tick during CONV:** cannot occur, because `TICK_CYCLES` ≥ 32 exceeds the refresh latency. The RTL carries an assertion for this.
- **Reset mid-operation:** the conversion is abandoned. No `bcd_valid` is produced until the first tick after `reset` is released.

## Timing
- With `tick` high in cycle T:
  - LOAD is in T+1;
  - the converter samples its input at the end of T+1 and shifts at the 14 edges ending T+2..T+15;
  - `done` is high in T+16;
  - new outputs and the `bcd_valid` pulse appear in T+17.
- The fixed latency is 17 cycles from tick to display update.
- The first tick after reset release is in cycle `TICK_CYCLES`-1, counting the first cycle with `reset` high as cycle 0.
- `bcd` holds its value between updates. The display never shows a partially converted value.

## Configuration
- Macro: `HAT_DISPLAY_EN`.
- **Defined:** four modes rotate, and mode 3 shows `hat`.
- **Undefined:**
  - three modes rotate, and `mode` never equals 3;
  - the `hat` port remains but is ignored;
  - the mode-advance logic wraps from 2 to 0.

## Structure
- **Package `stat_disp_pkg`:**
  - mode constants `MODE_STEPS`=0, `MODE_DIST`=1, `MODE_OVER32`=2, `MODE_HAT`=3;
  - `SAT_LIMIT`=9999;
  - `DP_DIST`=4'b0010;
  - FSM state typedef (IDLE, LOAD, CONV).
- **Sub-module `bin2bcd_seq`:**
  - sequential double-dabble, 14-bit input, 16-bit BCD output;
  - `start`/`done` handshake; `start` is ignored while busy;
  - `done` arrives exactly 15 cycles after `start` is sampled.

## Test plan
All scenarios use `TICK_CYCLES`=32, `DWELL_S`=2 and `HAT_DISPLAY_EN` defined unless stated.
- **Reset and first tick:** `step_count`=1234, release `reset` → all outputs 0 until cycle 48; then `bcd`=16'h1234, `mode`=0, `sat`=0, and `bcd_valid` is high for exactly one cycle.
- **Rotation with decimal point:** `distance_x10`=57 → the second tick yields `mode`=1, `bcd`=16'h0057, `dp_mask`=4'b0010. The next tick refreshes with `mode` still 1.
- **Saturation:** `over32_s`=12000 in mode 2 → `bcd`=16'h9999, `sat`=1. Changing the input to 42 yields `bcd`=16'h0042, `sat`=0 on the next tick.
- **Hold:** with `hold`=1 across 6 ticks → `mode` is unchanged. A `step_count` change from 10 to 11 appears on the next refresh.
- **Wrap:** mode 3 with `hat`=600 shows 16'h0600, then wraps to mode 0. With the macro undefined, the sequence is 2→0 and `hat` never appears.
- **Reset mid-conversion:** pull `reset` low at T+8 → all outputs are 0 in the same cycle. After release, no `bcd_valid` occurs before the next tick plus 17 cycles.
